// File: rtl/vigenere_stream_decryptor.sv
// Streaming Vigenere decryptor with valid/ready handshakes, a captured key and a 2-entry output FIFO.
// Optional build macro VIGENERE_NONALPHA_PASS_EN forwards non-letter bytes unchanged instead of dropping them.
module vigenere_stream_decryptor #(
  parameter int KEY_LEN = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [8*KEY_LEN-1:0]         keyInput,
  input  logic                         load,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_char,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_char,
  output logic [$clog2(KEY_LEN)-1:0]   key_index,
  output logic                         key_error,
  output logic                         dbg_state
);

  // Handshake: a byte moves on a side exactly in a cycle where its valid and ready are both 1 at the rising edge.
  localparam int IDX_W = $clog2(KEY_LEN);

  typedef enum logic {NOKEY = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [8*KEY_LEN-1:0]   key_q, key_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   kerr_q, kerr_d;
  logic [7:0]             fifo_q [2];
  logic [7:0]             fifo_d [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;

  logic [7:0] cur_key;
  logic       key_ok;
  logic [5:0] shift6;
  logic [5:0] c6;
  logic [5:0] diff6;
  logic [5:0] plain6;
  logic [7:0] plain;
  logic       is_letter;
  logic       accept;
  logic       push;
  logic       pop;
  logic [7:0] push_char;
  logic       load_err;

  always_comb begin
    cur_key = 8'd0;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (idx_q == IDX_W'(i)) cur_key = key_q[8*(KEY_LEN-1-i) +: 8];
    end
    key_ok    = (cur_key >= 8'd65) && (cur_key <= 8'd90);
    shift6    = key_ok ? 6'(cur_key - 8'd65) : 6'd0;
    is_letter = (in_char >= 8'd65) && (in_char <= 8'd90);
    // Bias by 26 first so the 6-bit subtraction never goes negative (max 51).
    c6        = 6'(in_char - 8'd65);
    diff6     = c6 + 6'd26 - shift6;
    plain6    = (diff6 >= 6'd26) ? (diff6 - 6'd26) : diff6;
    plain     = 8'd65 + {2'b00, plain6};

    load_err = 1'b0;
    for (int i = 0; i < KEY_LEN; i++) begin
      if ((keyInput[8*i +: 8] < 8'd65) || (keyInput[8*i +: 8] > 8'd90)) load_err = 1'b1;
    end

    in_ready = (state_q == RUN) && (count_q != 2'd2) && !load;
    accept   = in_valid && in_ready;
`ifdef VIGENERE_NONALPHA_PASS_EN
    push      = accept;
    push_char = is_letter ? plain : in_char;
`else
    push      = accept && is_letter;
    push_char = plain;
`endif
    pop = (count_q != 2'd0) && out_ready;
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    idx_d     = idx_q;
    kerr_d    = kerr_q;
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (load) begin
      state_d  = RUN;
      key_d    = keyInput;
      idx_d    = '0;
      kerr_d   = load_err;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = push_char;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (accept && is_letter) begin
        idx_d = (idx_q == IDX_W'(KEY_LEN-1)) ? '0 : idx_q + 1'b1;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= NOKEY;
      key_q     <= '0;
      idx_q     <= '0;
      kerr_q    <= 1'b0;
      fifo_q[0] <= 8'd0;
      fifo_q[1] <= 8'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
      kerr_q    <= kerr_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_char  = fifo_q[rd_ptr_q];
  assign key_index = idx_q;
  assign key_error = kerr_q;
  assign dbg_state = (state_q == RUN);

endmodule
